// File: rtl/clk_div_ctrl.sv
// Clock-enable controller: derives ce / ce_double from the oscillator clock at a
// programmable power-of-two ratio, with boundary-aligned ratio switching and gating.
module clk_div_ctrl #(
  parameter logic [1:0] RESET_DIV = 2'd1
) (
  input  logic       clk_hf,
  input  logic       reset_n,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_div,
  output logic       cfg_ready,
  input  logic       gate_req,
  output logic       gate_ack,
  output logic       ce,
  output logic       ce_double,
  output logic [1:0] cur_div,
  output logic       switch_done,
  output logic [3:0] phase
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SWITCH_PEND = 2'd1,
    ST_GATED       = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [1:0] r_cur_div;
  logic [1:0] w_cur_div_next;
  logic [1:0] r_pend_div;
  logic [1:0] w_pend_div_next;
  logic       r_switch_done;
  logic       w_switch_done_next;

  logic [3:0] w_last;
  logic [3:0] w_half;
  logic       w_boundary;
  logic       w_handshake;

  // Last count of the period (N-1) and of its first half (N/2-1).
  always_comb begin
    w_last = 4'd3;
    w_half = 4'd1;
    case (r_cur_div)
      2'd0: begin w_last = 4'd1;  w_half = 4'd0; end
      2'd1: begin w_last = 4'd3;  w_half = 4'd1; end
      2'd2: begin w_last = 4'd7;  w_half = 4'd3; end
      2'd3: begin w_last = 4'd15; w_half = 4'd7; end
      default: begin w_last = 4'd3; w_half = 4'd1; end
    endcase
  end

  assign w_boundary  = (r_cnt == w_last);
  assign cfg_ready   = (r_state != ST_SWITCH_PEND);
  assign w_handshake = cfg_valid && cfg_ready;

  assign ce          = (r_state != ST_GATED) && w_boundary;
  assign ce_double   = (r_state != ST_GATED) && ((r_cnt == w_half) || w_boundary);
  assign gate_ack    = (r_state == ST_GATED);
  assign cur_div     = r_cur_div;
  assign switch_done = r_switch_done;
  assign phase       = r_cnt;

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = w_boundary ? 4'd0 : r_cnt + 4'd1;
    w_cur_div_next     = r_cur_div;
    w_pend_div_next    = r_pend_div;
    w_switch_done_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A handshake wins over a gate request; the gate is honoured at the switching boundary.
        if (w_handshake) begin
          w_pend_div_next = cfg_div;
          w_state_next    = ST_SWITCH_PEND;
        end else if (w_boundary && gate_req) begin
          w_state_next = ST_GATED;
        end
      end
      ST_SWITCH_PEND: begin
        if (w_boundary) begin
          w_cur_div_next     = r_pend_div;
          w_switch_done_next = 1'b1;
          w_state_next       = gate_req ? ST_GATED : ST_RUN;
        end
      end
      ST_GATED: begin
        w_cnt_next = 4'd0;
        if (w_handshake) begin
          w_cur_div_next     = cfg_div;
          w_switch_done_next = 1'b1;
        end
        if (!gate_req) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_hf or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_cnt         <= 4'd0;
      r_cur_div     <= RESET_DIV;
      r_pend_div    <= RESET_DIV;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cur_div     <= w_cur_div_next;
      r_pend_div    <= w_pend_div_next;
      r_switch_done <= w_switch_done_next;
    end
  end

endmodule
